// File: rtl/mic_capture_ctrl.sv
// Microphone capture sequencer: free-running ADCLRC generator, frame-aligned
// capture FSM, block framing and a 2-entry ready/valid output buffer.
module mic_capture_ctrl #(
    parameter int N              = 16,
    parameter int BCLK_PER_FRAME = 384,
    parameter int BLOCK_LEN      = 1024,
    parameter int OVF_W          = 8
) (
    input  logic             bclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    output logic             adclrc,
    input  logic             sample_valid,
    input  logic [N-1:0]     sample_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_last,
    output logic             busy,
    output logic [OVF_W-1:0] overrun_count
);

    localparam int FC_W = $clog2(BCLK_PER_FRAME);
    localparam int SI_W = $clog2(BLOCK_LEN);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    logic [FC_W-1:0]  fc_reg;
    logic [FC_W-1:0]  fc_next;
    logic             adclrc_reg;
    logic             frame_start;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic             busy_reg;
    logic             stop_pend_reg;
    logic [SI_W-1:0]  si_reg;
    logic             si_last;
    logic [OVF_W-1:0] ovf_reg;

    logic [N-1:0]     data_reg [2];
    logic             last_reg [2];
    logic [1:0]       count_reg;
    logic [1:0]       wr_pos;
    logic             slot;
    logic             pop;
    logic             room;
    logic             push;
    logic             drop;

    // Frame generator runs regardless of the FSM so the codec always sees ADCLRC.
    assign fc_next     = (fc_reg == FC_W'(BCLK_PER_FRAME - 1)) ? '0 : fc_reg + 1'b1;
    assign frame_start = (fc_next == '0);

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            fc_reg     <= FC_W'(BCLK_PER_FRAME - 1);
            adclrc_reg <= 1'b0;
        end else begin
            fc_reg     <= fc_next;
            adclrc_reg <= (fc_next < FC_W'(BCLK_PER_FRAME / 2));
        end
    end

    assign si_last = (si_reg == SI_W'(BLOCK_LEN - 1));
    assign slot    = (state_reg == ST_CAPTURE) && sample_valid;
    assign pop     = (count_reg != 2'd0) && out_ready;
    assign room    = (count_reg != 2'd2) || pop;
    assign push    = slot && room;
    assign drop    = slot && !room;
    assign wr_pos  = count_reg - {1'b0, pop};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (start && !stop) state_next = ST_ARM;
            ST_ARM: begin
                if (stop)             state_next = ST_IDLE;
                else if (frame_start) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: if (slot && si_last && (stop_pend_reg || stop)) state_next = ST_DRAIN;
            ST_DRAIN:   if (count_reg == 2'd0) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
            stop_pend_reg <= 1'b0;
            si_reg        <= '0;
            ovf_reg       <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != ST_IDLE);
            if (state_next == ST_IDLE)
                stop_pend_reg <= 1'b0;
            else if ((state_reg == ST_CAPTURE) && stop)
                stop_pend_reg <= 1'b1;
            // Every slot advances the index, dropped or not, so blocks stay aligned.
            if ((state_reg == ST_ARM) && frame_start)
                si_reg <= '0;
            else if (slot)
                si_reg <= si_last ? '0 : si_reg + 1'b1;
            if (drop && (ovf_reg != '1))
                ovf_reg <= ovf_reg + 1'b1;
        end
    end

    // Entry 0 is the head; a pop shifts entry 1 down, a push writes behind the survivors.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg[0] <= '0;
            data_reg[1] <= '0;
            last_reg[0] <= 1'b0;
            last_reg[1] <= 1'b0;
            count_reg   <= 2'd0;
        end else begin
            if (pop) begin
                data_reg[0] <= data_reg[1];
                last_reg[0] <= last_reg[1];
            end
            if (push && (wr_pos == 2'd0)) begin
                data_reg[0] <= sample_data;
                last_reg[0] <= si_last;
            end
            if (push && (wr_pos == 2'd1)) begin
                data_reg[1] <= sample_data;
                last_reg[1] <= si_last;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign adclrc        = adclrc_reg;
    assign out_valid     = (count_reg != 2'd0);
    assign out_data      = data_reg[0];
    assign out_last      = last_reg[0];
    assign busy          = busy_reg;
    assign overrun_count = ovf_reg;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Directed bench for mic_capture_ctrl with a scoreboard of expected buffer outputs.
module tb_mic_capture_ctrl;

    localparam int N   = 16;
    localparam int BPF = 32;
    localparam int BL  = 4;
    localparam int OW  = 8;

    logic          bclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          adclrc;
    logic          sample_valid = 1'b0;
    logic [N-1:0]  sample_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic [OW-1:0] overrun_count;

    int            pass_cnt = 0;
    int            total_cnt = 0;
    int            fc_m = BPF - 1;
    int            exp_ovf;
    logic [N:0]    exp_q[$];
    logic [N:0]    exp_item;

    mic_capture_ctrl #(
        .N(N), .BCLK_PER_FRAME(BPF), .BLOCK_LEN(BL), .OVF_W(OW)
    ) dut (
        .bclk(bclk), .rst_n(rst_n), .start(start), .stop(stop), .adclrc(adclrc),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .overrun_count(overrun_count)
    );

    always #5 bclk = ~bclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge bclk);
        fc_m = (fc_m + 1) % BPF;
        #1;
    endtask

    task automatic wait_fc(input int v);
        step();
        while (fc_m != v) step();
    endtask

    task automatic drive_sample(input logic [N-1:0] d, input bit expect_push, input bit exp_last);
        sample_valid = 1'b1;
        sample_data  = d;
        if (expect_push) exp_q.push_back({exp_last, d});
    endtask

    // Output monitor: one line per accepted transaction, checked against the scoreboard.
    always @(negedge bclk) begin
        if (rst_n && out_valid && out_ready) begin
            chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_item = exp_q.pop_front();
                $display("pop data=%h last=%b (expected data=%h last=%b)",
                         out_data, out_last, exp_item[N-1:0], exp_item[N]);
                chk("out_data", 32'(out_data), 32'(exp_item[N-1:0]));
                chk("out_last", 32'(out_last), 32'(exp_item[N]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge bclk);
        #1;
        chk("rst_adclrc", 32'(adclrc), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overrun_count), 32'd0);
        rst_n = 1'b1;
        fc_m  = BPF - 1;

        // Free-running ADCLRC: high for fc 0..15, low for 16..31
        for (int k = 0; k < 2 * BPF; k++) begin
            step();
            chk($sformatf("adclrc_k%0d", k), 32'(adclrc), 32'(fc_m < BPF / 2));
            if (k == 0) chk("adclrc_first_rise", 32'(adclrc), 32'd1);
        end
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Arm at fc=5; the sample inside the partial frame is ignored
        out_ready = 1'b1;
        wait_fc(5);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("arm_busy", 32'(busy), 32'd1);
        wait_fc(10);
        drive_sample(16'h0BAD, 1'b0, 1'b0);
        step();
        sample_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_fc(10);
            drive_sample(16'h1111 * (i + 1), 1'b1, i == 3);
            step();
            sample_valid = 1'b0;
            chk("lat_out_valid", 32'(out_valid), 32'd1);
            chk("lat_out_data", 32'(out_data), 32'(16'h1111 * (i + 1)));
        end
        step();
        chk("arm_ovf", 32'(overrun_count), 32'd0);
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // Stalled output: two buffered, two dropped, 4th slot still ends the block
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_sample(16'hA001 + 16'(i), i < 2, 1'b0);
            step();
        end
        sample_valid = 1'b0;
        chk("stall_ovf", 32'(overrun_count), 32'd2);
        repeat (3) step();
        chk("stall_hold_valid", 32'(out_valid), 32'd1);
        chk("stall_hold_data", 32'(out_data), 32'hA001);
        out_ready = 1'b1;
        repeat (3) step();
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
        chk("t3_out_valid", 32'(out_valid), 32'd0);

        // Stop during 2nd sample: block completes, then drain to idle
        for (int i = 0; i < 4; i++) begin
            drive_sample(16'hB001 + 16'(i), 1'b1, i == 3);
            stop = (i == 1);
            step();
        end
        sample_valid = 1'b0;
        stop = 1'b0;
        chk("drain_busy", 32'(busy), 32'd1);
        step();
        chk("drain_empty_valid", 32'(out_valid), 32'd0);
        chk("drain_busy_hold", 32'(busy), 32'd1);
        step();
        chk("drain_busy_fall", 32'(busy), 32'd0);
        drive_sample(16'hC0DE, 1'b0, 1'b0);
        repeat (2) step();
        sample_valid = 1'b0;
        chk("idle_no_push", 32'(out_valid), 32'd0);
        chk("idle_ovf", 32'(overrun_count), 32'd2);

        // Full buffer with simultaneous pop and push: nothing dropped
        wait_fc(5);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_fc(0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out_ready = (i >= 2);
            drive_sample(16'hD001 + 16'(i), 1'b1, i == 3);
            step();
        end
        sample_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("full_pp_ovf", 32'(overrun_count), 32'd2);
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

        // Saturation of the overrun counter
        out_ready = 1'b0;
        exp_ovf = 2;
        for (int k = 0; k < 302; k++) begin
            if (k >= 2 && exp_ovf < 255) exp_ovf++;
            drive_sample(16'(k), k < 2, 1'b0);
            step();
            if (k == 101 || k == 255 || k == 301)
                chk($sformatf("ovf_k%0d", k), 32'(overrun_count), 32'(exp_ovf));
        end
        sample_valid = 1'b0;
        chk("ovf_sat", 32'(overrun_count), 32'd255);

        // Asynchronous reset mid-capture with a full buffer
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("arst_adclrc", 32'(adclrc), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_last", 32'(out_last), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ovf", 32'(overrun_count), 32'd0);
        @(posedge bclk);
        #1;
        rst_n = 1'b1;
        fc_m  = BPF - 1;
        for (int k = 0; k < BPF; k++) begin
            step();
            chk($sformatf("post_rst_adclrc_k%0d", k), 32'(adclrc), 32'(fc_m < BPF / 2));
        end
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
